mc_cu: RTL and testbench
========================

# mc_cu

Multicycle MIPS control unit for the mc_computer datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives per-cycle datapath strobes and handshakes with a shared instruction/data memory port that may take several cycles to answer. It supports the same 20-instruction subset as the single-cycle machine:

- R-type: add, sub, and, or, xor, sll, srl, sra, jr
- I-type: addi, andi, ori, xori, lw, sw, beq, bne, lui
- J-type: j, jal

## Interface
- HANDSHAKE, 1: 1 = wait for mem_rdy; 0 = treat mem_rdy as constant 1.
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26] from IR
- func  in  6  instruction[5:0] from IR
- z  in  1  ALU zero flag (combinational from ALU in the same cycle)
- mem_rdy  in  1  memory completes the requested access this cycle
- mem_req  out  1  memory access requested
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- wir  out  1  load IR
- wpc  out  1  load PC
- pcsource  out  2  PC mux select: 00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = rs (jr), 11 = jump address
- wmem  out  1  memory write
- wreg  out  1  register-file write
- regrt  out  1  destination register select: 1 = rt, 0 = rd
- m2reg  out  1  write-back from MDR
- jal  out  1  destination register = r31, write data = PC
- aluc  out  4  ALU operation code
  - add x000, sub x100, and x001, or x101, xor x010, lui x110
  - sll 0011, srl 0111, sra 1111
- shift  out  1  ALU A input = sa
- alusrca  out  1  ALU A input: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = sext(imm)<<2
- sext  out  1  immediate extension: 1 = sign extend, 0 = zero extend
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in ID for an unsupported op/func
- state  out  3  current state, for debug

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5–7 are unreachable and must go to IF.
- Every output is combinational from state plus the decoded instruction. Unlisted outputs are 0.
- **IF**
  - Drives mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - On mem_rdy: wir=1, wpc=1, go to ID. Otherwise hold in IF with wir=wpc=0.
- **ID**
  - Drives alusrca=0, alusrcb=11, aluc=add, sext=1, so the datapath latches the branch target into ALUOut.
  - j: wpc=1, pcsource=11, go to IF, retire.
  - jal: as j, plus wreg=1 and jal=1 (writes PC+4 to r31).
  - jr: wpc=1, pcsource=10, go to IF, retire.
  - Unsupported op/func: illegal=1, retire=1, go to IF; no other write strobe.
  - All other instructions: go to EXE.
- **EXE**
  - alusrca=1. shift=1 for sll/srl/sra.
  - alusrcb=00 for R-type, beq and bne; 10 for addi/andi/ori/xori/lw/sw/lui.
  - sext=1 for addi/lw/sw/beq/bne; 0 otherwise.
  - aluc per the codes above. beq/bne use sub; lw/sw use add.
  - beq/bne: wpc = (beq & z) | (bne & ~z), pcsource=01, go to IF, retire.
  - lw/sw: go to MEM. All others: go to WB.
- **MEM**
  - mem_req=1, iord=1.
  - sw: wmem=1 only in the mem_rdy cycle; then go to IF and retire.
  - lw: on mem_rdy go to WB. Without mem_rdy, hold in MEM.
- **WB**
  - wreg=1, retire=1, go to IF.
  - regrt=1 for I-type, 0 for R-type.
  - m2reg=1 for lw.
- The decode and the z-based branch decision use op/func/z as presented in the current cycle. The IR holds op/func stable from ID onward.

## Timing
- Reset: the state register clears to IF asynchronously. While resetn=0, every output is forced to 0, including mem_req.
  - Reset asserted mid-instruction aborts it: no further strobes, no retire.
- First fetch request is in the first cycle after resetn deasserts.
- Latency in cycles with mem_rdy always 1:
  - 2 cycles: j, jal, jr, illegal
  - 3 cycles: beq, bne
  - 4 cycles: R-type ALU ops, I-type ALU ops, sw
  - 5 cycles: lw
- Each stall cycle in IF or MEM adds exactly one cycle.
- mem_req stays high for the whole wait. It drops the cycle after the mem_rdy cycle.
- mem_rdy is ignored outside IF and MEM.
- retire, wpc and wreg are single-cycle pulses. They are never asserted while stalled.

## Structure
- Package mc_cu_pkg holds:
  - state encodings
  - opcode and func constants
  - aluc codes
  - alusrcb and pcsource codes
- One sub-module, mc_decode: combinational decode of op/func into one-hot instruction flags plus an is_legal output.
- mc_cu itself holds the state register, next-state logic and output logic.

## Test plan
- add (op=0, func=100000), mem_rdy=1 → states IF, ID, EXE, WB.
  - EXE: aluc=0000, alusrcb=00. WB: wreg=1, regrt=0. retire asserts in cycle 4.
- lw (op=100011) with mem_rdy low for 2 cycles in IF and 3 cycles in MEM → 10 cycles total.
  - mem_req continuous in each wait. WB: m2reg=1, regrt=1.
- beq (op=000100): with z=1 → EXE gives wpc=1, pcsource=01. With z=0 → wpc=0. Both retire in cycle 3.
- jal (op=000011) → ID gives wpc=1, pcsource=11, wreg=1, jal=1. Next state is IF.
- sw (op=101011), then op=111111 → sw: wmem=1 exactly once, in the mem_rdy cycle. op=111111: illegal pulse in ID, no wreg/wmem/wpc.
- resetn driven low in EXE of sra → all outputs 0 immediately, state=IF.
  - After release: mem_req=1 and iord=0 in the next cycle.

Source files
------------

// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: shared constants and types for the multicycle MIPS control unit.
// Holds the state encodings, opcode/func values, ALU operation codes, ALU B
// and PC mux select codes, the one-hot decoded-instruction record and a helper
// that maps a decoded instruction onto its ALU operation.
package mc_cu_pkg;

  // Controller states; 5..7 are never entered and recover to IF.
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Primary opcodes (instruction[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction[5:0]).
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // ALU operation codes (don't-care top bit driven as 0 where allowed).
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  // ALU B input select.
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC mux select.
  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_ALUO = 2'b01;
  localparam logic [1:0] PCS_RS   = 2'b10;
  localparam logic [1:0] PCS_JUMP = 2'b11;

  // One-hot decoded instruction; all zero for an unsupported encoding.
  typedef struct packed {
    logic f_add;
    logic f_sub;
    logic f_and;
    logic f_or;
    logic f_xor;
    logic f_sll;
    logic f_srl;
    logic f_sra;
    logic f_jr;
    logic f_addi;
    logic f_andi;
    logic f_ori;
    logic f_xori;
    logic f_lw;
    logic f_sw;
    logic f_beq;
    logic f_bne;
    logic f_lui;
    logic f_j;
    logic f_jal;
  } instr_t;

  // ALU operation for the EXE cycle; branches compare by subtraction and
  // memory ops form their address by addition.
  function automatic logic [3:0] alu_code(input instr_t d);
    logic [3:0] c;
    c = ALU_ADD;
    if (d.f_sub || d.f_beq || d.f_bne) c = ALU_SUB;
    if (d.f_and || d.f_andi)           c = ALU_AND;
    if (d.f_or  || d.f_ori)            c = ALU_OR;
    if (d.f_xor || d.f_xori)           c = ALU_XOR;
    if (d.f_lui)                       c = ALU_LUI;
    if (d.f_sll)                       c = ALU_SLL;
    if (d.f_srl)                       c = ALU_SRL;
    if (d.f_sra)                       c = ALU_SRA;
    return c;
  endfunction

endpackage

// File: rtl/mc_cu_decode.sv
// mc_decode: purely combinational instruction decoder.
// Ports:
//   i_op       - instruction[31:26]
//   i_func     - instruction[5:0]
//   o_flags    - one-hot record of the recognised instruction
//   o_is_legal - 1 when op/func is one of the supported instructions
module mc_decode
  import mc_cu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output instr_t     o_flags,
  output logic       o_is_legal
);

  logic w_r;

  assign w_r = (i_op == OP_RTYPE);

  always_comb begin
    o_flags        = '0;
    o_flags.f_add  = w_r && (i_func == FN_ADD);
    o_flags.f_sub  = w_r && (i_func == FN_SUB);
    o_flags.f_and  = w_r && (i_func == FN_AND);
    o_flags.f_or   = w_r && (i_func == FN_OR);
    o_flags.f_xor  = w_r && (i_func == FN_XOR);
    o_flags.f_sll  = w_r && (i_func == FN_SLL);
    o_flags.f_srl  = w_r && (i_func == FN_SRL);
    o_flags.f_sra  = w_r && (i_func == FN_SRA);
    o_flags.f_jr   = w_r && (i_func == FN_JR);
    o_flags.f_addi = (i_op == OP_ADDI);
    o_flags.f_andi = (i_op == OP_ANDI);
    o_flags.f_ori  = (i_op == OP_ORI);
    o_flags.f_xori = (i_op == OP_XORI);
    o_flags.f_lw   = (i_op == OP_LW);
    o_flags.f_sw   = (i_op == OP_SW);
    o_flags.f_beq  = (i_op == OP_BEQ);
    o_flags.f_bne  = (i_op == OP_BNE);
    o_flags.f_lui  = (i_op == OP_LUI);
    o_flags.f_j    = (i_op == OP_J);
    o_flags.f_jal  = (i_op == OP_JAL);
  end

  assign o_is_legal = |o_flags;

endmodule

// File: rtl/mc_cu.sv
// mc_cu: multicycle MIPS control unit (IF -> ID -> EXE -> MEM -> WB).
// Holds the state register and produces every datapath strobe
// combinationally from the current state and the decoded instruction.
// Ports:
//   clock, resetn     - rising-edge clock, asynchronous active-low reset
//   op, func, z       - IR fields and ALU zero flag
//   mem_rdy           - shared memory completes the access this cycle
//   mem_req, iord     - memory request and address select (PC / ALUOut)
//   wir, wpc, wmem, wreg - IR / PC / memory / register-file write strobes
//   pcsource          - PC mux select
//   regrt, m2reg, jal - write-back destination and data selects
//   aluc, shift, alusrca, alusrcb, sext - ALU operation and operand selects
//   retire, illegal   - end-of-instruction and unsupported-instruction pulses
//   state             - current state for debug
// HANDSHAKE=0 ties the memory ready to 1 for single-cycle memories.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter bit HANDSHAKE = 1'b1
)(
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       iord,
  output logic       wir,
  output logic       wpc,
  output logic [1:0] pcsource,
  output logic       wmem,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  instr_t     w_d;
  logic       w_legal;
  logic       w_rdy;
  logic       w_rtype;
  logic       w_take;

  mc_decode u_decode (
    .i_op       (op),
    .i_func     (func),
    .o_flags    (w_d),
    .o_is_legal (w_legal)
  );

  assign w_rdy   = HANDSHAKE ? mem_rdy : 1'b1;
  assign w_rtype = w_d.f_add | w_d.f_sub | w_d.f_and | w_d.f_or | w_d.f_xor |
                   w_d.f_sll | w_d.f_srl | w_d.f_sra;
  assign w_take  = (w_d.f_beq & z) | (w_d.f_bne & ~z);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IF;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = S_IF;
    mem_req  = 1'b0;
    iord     = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    pcsource = PCS_ALU;
    wmem     = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    aluc     = ALU_ADD;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    sext     = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    state    = r_state;

    case (r_state)
      S_IF: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        wir     = w_rdy;
        wpc     = w_rdy;
        w_next  = w_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        alusrcb = SRCB_BOFF;
        sext    = 1'b1;
        w_next  = S_EXE;
        if (!w_legal) begin
          illegal = 1'b1;
          retire  = 1'b1;
          w_next  = S_IF;
        end else if (w_d.f_j || w_d.f_jal) begin
          wpc      = 1'b1;
          pcsource = PCS_JUMP;
          wreg     = w_d.f_jal;
          jal      = w_d.f_jal;
          retire   = 1'b1;
          w_next   = S_IF;
        end else if (w_d.f_jr) begin
          wpc      = 1'b1;
          pcsource = PCS_RS;
          retire   = 1'b1;
          w_next   = S_IF;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        shift   = w_d.f_sll | w_d.f_srl | w_d.f_sra;
        alusrcb = (w_rtype | w_d.f_beq | w_d.f_bne) ? SRCB_RT : SRCB_IMM;
        sext    = w_d.f_addi | w_d.f_lw | w_d.f_sw | w_d.f_beq | w_d.f_bne;
        aluc    = alu_code(w_d);
        if (w_d.f_beq || w_d.f_bne) begin
          wpc      = w_take;
          pcsource = PCS_ALUO;
          retire   = 1'b1;
          w_next   = S_IF;
        end else if (w_d.f_lw || w_d.f_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (w_d.f_sw) begin
          wmem   = w_rdy;
          retire = w_rdy;
          w_next = w_rdy ? S_IF : S_MEM;
        end else begin
          w_next = w_rdy ? S_WB : S_MEM;
        end
      end
      S_WB: begin
        wreg   = 1'b1;
        retire = 1'b1;
        regrt  = ~w_rtype;
        m2reg  = w_d.f_lw;
        w_next = S_IF;
      end
      default: w_next = S_IF;
    endcase

    // Reset silences the whole strobe set, not just the state register.
    if (!resetn) begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      wir      = 1'b0;
      wpc      = 1'b0;
      pcsource = 2'b00;
      wmem     = 1'b0;
      wreg     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      jal      = 1'b0;
      aluc     = 4'b0000;
      shift    = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      sext     = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
      state    = S_IF;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
module tb_mc_cu;

  logic       clock;
  logic       resetn;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_rdy;
  logic       mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal;
  logic       shift, alusrca, sext, retire, illegal;
  logic [1:0] pcsource, alusrcb;
  logic [3:0] aluc;
  logic [2:0] state;

  int checks;
  int failures;
  int cyc;
  int cnt;

  mc_cu #(.HANDSHAKE(1'b1)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
    .mem_rdy(mem_rdy), .mem_req(mem_req), .iord(iord), .wir(wir), .wpc(wpc),
    .pcsource(pcsource), .wmem(wmem), .wreg(wreg), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .aluc(aluc), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .sext(sext), .retire(retire), .illegal(illegal),
    .state(state)
  );

  wire [24:0] all_out = {state, mem_req, iord, wir, wpc, pcsource, wmem, wreg,
                         regrt, m2reg, jal, aluc, shift, alusrca, alusrcb,
                         sext, retire, illegal};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; op = 6'b000000; func = 6'b100000; z = 1'b1; mem_rdy = 1'b1;
    #2;
    checks++;
    if (all_out !== 25'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", all_out, 25'd0);
    end
    tick(); tick();
    checks++;
    if (all_out !== 25'd0) begin
      failures++; $display("FAIL reset_held got=%h exp=%h", all_out, 25'd0);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if ({state, mem_req, iord, wir} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_first_fetch got=%b exp=%b",
                           {state, mem_req, iord, wir}, {3'd0, 3'b101});
    end
  endtask

  task automatic test_add();
    op = 6'b000000; func = 6'b100000; mem_rdy = 1'b1; cyc = 1; cnt = 0;
    #1;
    checks++;
    if ({state, mem_req, iord, wir, wpc, pcsource, alusrca, alusrcb, aluc, retire}
        !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 4'b0000, 1'b0}) begin
      failures++; $display("FAIL add_if got=%b", {state, mem_req, iord, wir, wpc,
                           pcsource, alusrca, alusrcb, aluc, retire});
    end
    tick();
    checks++;
    if ({state, alusrca, alusrcb, sext, aluc, wpc, wreg, retire, mem_req}
        !== {3'd1, 1'b0, 2'b11, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_id got=%b", {state, alusrca, alusrcb, sext,
                           aluc, wpc, wreg, retire, mem_req});
    end
    tick();
    checks++;
    if ({state, alusrca, alusrcb, aluc, shift, wreg, retire}
        !== {3'd2, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_exe got=%b", {state, alusrca, alusrcb, aluc,
                           shift, wreg, retire});
    end
    tick();
    checks++;
    if ({state, wreg, regrt, m2reg, retire, wpc, cyc}
        !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4}) begin
      failures++; $display("FAIL add_wb got=%b exp=%b", {state, wreg, regrt, m2reg,
                           retire, wpc}, {3'd4, 5'b10010});
    end
    tick();
    checks++;
    if ({state, retire, wreg} !== {3'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_back_to_if got=%b exp=%b", {state, retire, wreg}, 5'b00000);
    end
  endtask

  task automatic test_lw();
    op = 6'b100011; func = 6'b000000; cyc = 1; cnt = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rdy = 1'b0;
      #1;
      if ({state, mem_req, iord, wir, wpc} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) cnt++;
      tick();
    end
    mem_rdy = 1'b1;
    #1;
    if ({state, mem_req, wir, wpc} !== {3'd0, 1'b1, 1'b1, 1'b1}) cnt++;
    checks++;
    if (cnt != 0) begin
      failures++; $display("FAIL lw_if_stall bad_cycles=%0d exp=0", cnt);
    end
    tick();
    mem_rdy = 1'b0;
    #1;
    checks++;
    if ({state, retire, wpc} !== {3'd1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL lw_id_ignores_rdy got=%b exp=%b", {state, retire, wpc}, {3'd1, 2'b00});
    end
    tick();
    #1;
    checks++;
    if ({state, alusrca, alusrcb, sext, aluc} !== {3'd2, 1'b1, 2'b10, 1'b1, 4'b0000}) begin
      failures++; $display("FAIL lw_exe got=%b", {state, alusrca, alusrcb, sext, aluc});
    end
    tick();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rdy = 1'b0;
      #1;
      if ({state, mem_req, iord, wmem, retire, wreg} !== {3'd3, 1'b1, 1'b1, 3'b000}) cnt++;
      tick();
    end
    mem_rdy = 1'b1;
    #1;
    if ({state, mem_req, iord, retire} !== {3'd3, 1'b1, 1'b1, 1'b0}) cnt++;
    checks++;
    if (cnt != 0) begin
      failures++; $display("FAIL lw_mem_stall bad_cycles=%0d exp=0", cnt);
    end
    tick();
    checks++;
    if ({state, wreg, regrt, m2reg, retire, mem_req} !== {3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL lw_wb got=%b exp=%b", {state, wreg, regrt, m2reg, retire, mem_req},
                           {3'd4, 5'b11110});
    end
    checks++;
    if (cyc != 10) begin
      failures++; $display("FAIL lw_latency got=%0d exp=10", cyc);
    end
    tick();
  endtask

  task automatic test_beq(input logic zv);
    op = 6'b000100; func = 6'b000000; mem_rdy = 1'b1; z = zv; cyc = 1;
    tick(); tick();
    #1;
    checks++;
    if ({state, wpc, pcsource, retire, aluc, alusrcb, sext, cyc}
        !== {3'd2, zv, 2'b01, 1'b1, 4'b0100, 2'b00, 1'b1, 32'd3}) begin
      failures++; $display("FAIL beq_exe_z%0d got=%b", zv,
                           {state, wpc, pcsource, retire, aluc, alusrcb, sext});
    end
    z = ~zv;
    #1;
    checks++;
    if (wpc !== ~zv) begin
      failures++; $display("FAIL beq_z_live got=%b exp=%b", wpc, ~zv);
    end
    z = zv;
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++; $display("FAIL beq_next got=%0d exp=0", state);
    end
  endtask

  task automatic test_jal();
    op = 6'b000011; func = 6'b000000; mem_rdy = 1'b1;
    tick();
    #1;
    checks++;
    if ({state, wpc, pcsource, wreg, jal, retire, illegal}
        !== {3'd1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL jal_id got=%b", {state, wpc, pcsource, wreg, jal, retire, illegal});
    end
    tick();
    checks++;
    if ({state, wreg, jal} !== {3'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL jal_next got=%b exp=%b", {state, wreg, jal}, 5'b00000);
    end
  endtask

  task automatic test_jr();
    op = 6'b000000; func = 6'b001000; mem_rdy = 1'b1;
    tick();
    #1;
    checks++;
    if ({state, wpc, pcsource, wreg, retire} !== {3'd1, 1'b1, 2'b10, 1'b0, 1'b1}) begin
      failures++; $display("FAIL jr_id got=%b", {state, wpc, pcsource, wreg, retire});
    end
    tick();
  endtask

  task automatic test_sw();
    op = 6'b101011; func = 6'b000000; mem_rdy = 1'b1; cnt = 0;
    #1; if (wmem) cnt++;
    tick(); #1; if (wmem) cnt++;
    tick(); #1;
    checks++;
    if ({state, alusrcb, sext, aluc} !== {3'd2, 2'b10, 1'b1, 4'b0000}) begin
      failures++; $display("FAIL sw_exe got=%b", {state, alusrcb, sext, aluc});
    end
    if (wmem) cnt++;
    tick();
    mem_rdy = 1'b0;
    #1;
    checks++;
    if ({state, wmem, retire, mem_req, iord} !== {3'd3, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL sw_mem_wait got=%b", {state, wmem, retire, mem_req, iord});
    end
    tick();
    mem_rdy = 1'b1;
    #1;
    checks++;
    if ({state, wmem, retire, wreg} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sw_mem_rdy got=%b", {state, wmem, retire, wreg});
    end
    if (wmem) cnt++;
    tick(); #1; if (wmem) cnt++;
    checks++;
    if (cnt != 1 || state !== 3'd0) begin
      failures++; $display("FAIL sw_wmem_once got=%0d state=%0d exp=1 state=0", cnt, state);
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111; func = 6'b000000; mem_rdy = 1'b1;
    tick();
    #1;
    checks++;
    if ({state, illegal, retire, wreg, wmem, wpc} !== {3'd1, 1'b1, 1'b1, 3'b000}) begin
      failures++; $display("FAIL illegal_id got=%b", {state, illegal, retire, wreg, wmem, wpc});
    end
    tick();
    checks++;
    if ({state, illegal} !== {3'd0, 1'b0}) begin
      failures++; $display("FAIL illegal_pulse got=%b exp=%b", {state, illegal}, 4'b0000);
    end
    func = 6'b111111; op = 6'b000000;
    tick();
    #1;
    checks++;
    if ({state, illegal, retire} !== {3'd1, 1'b1, 1'b1}) begin
      failures++; $display("FAIL illegal_func got=%b", {state, illegal, retire});
    end
    tick();
  endtask

  task automatic test_shift_imm();
    op = 6'b000000; func = 6'b000000; mem_rdy = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({state, shift, aluc, alusrcb, sext} !== {3'd2, 1'b1, 4'b0011, 2'b00, 1'b0}) begin
      failures++; $display("FAIL sll_exe got=%b", {state, shift, aluc, alusrcb, sext});
    end
    tick(); tick();
    op = 6'b001101;
    tick(); tick(); #1;
    checks++;
    if ({state, shift, aluc, alusrcb, sext} !== {3'd2, 1'b0, 4'b0101, 2'b10, 1'b0}) begin
      failures++; $display("FAIL ori_exe got=%b", {state, shift, aluc, alusrcb, sext});
    end
    tick();
    checks++;
    if ({state, wreg, regrt, m2reg} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL ori_wb got=%b", {state, wreg, regrt, m2reg});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    op = 6'b000000; func = 6'b000011; mem_rdy = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({state, shift, aluc} !== {3'd2, 1'b1, 4'b1111}) begin
      failures++; $display("FAIL sra_exe got=%b", {state, shift, aluc});
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (all_out !== 25'd0) begin
      failures++; $display("FAIL reset_mid got=%h exp=0", all_out);
    end
    tick();
    checks++;
    if (all_out !== 25'd0) begin
      failures++; $display("FAIL reset_mid_held got=%h exp=0", all_out);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if ({state, mem_req, iord, retire} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_mid_release got=%b", {state, mem_req, iord, retire});
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; cnt = 0;
    resetn = 1'b0; op = '0; func = '0; z = 1'b0; mem_rdy = 1'b0;
    #2;
    test_reset();
    test_add();
    test_lw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_jr();
    test_sw();
    test_illegal();
    test_shift_imm();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
